// File: rtl/k423_pkg.sv
// Shared types and constants for the k423 writeback stage.
package k423_pkg;

    localparam int unsigned CORE_XLEN     = 32;
    localparam int unsigned INST_RSDIDX_W = 5;
    localparam int unsigned RSD_SIZE_W    = 2;

    // Load size encodings.
    localparam logic [RSD_SIZE_W-1:0] RSD_SIZE_BYTE = 2'd0;
    localparam logic [RSD_SIZE_W-1:0] RSD_SIZE_HALF = 2'd1;
    localparam logic [RSD_SIZE_W-1:0] RSD_SIZE_WORD = 2'd2;

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StWait  = 2'd1,
        StDone  = 2'd2
    } wb_state_e;

    // One retiring instruction held by WB.
    typedef struct packed {
        logic                     rd_vld;
        logic [INST_RSDIDX_W-1:0] rd_idx;
        logic [CORE_XLEN-1:0]     data;
        logic                     load;
        logic [RSD_SIZE_W-1:0]    size;
        logic                     uns;
        logic [1:0]               addr_lo;
    } wb_entry_t;

endpackage

// File: rtl/k423_wb_load_align.sv
// Extracts the addressed byte/half from a load response word and extends it.
module k423_wb_load_align
    import k423_pkg::*;
#(
    parameter int unsigned XLEN = CORE_XLEN
) (
    input  logic [XLEN-1:0]       raw,
    input  logic [RSD_SIZE_W-1:0] size,
    input  logic                  uns,
    input  logic [1:0]            addr_lo,
    output logic [XLEN-1:0]       data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane select, then sign/zero extension by size.
    always_comb begin
        byte_sel = raw[{addr_lo, 3'b000} +: 8];
        // addr_lo[0] is ignored for halves; misaligned halves never reach WB.
        half_sel = raw[{addr_lo[1], 4'b0000} +: 16];
        data     = raw;
        case (size)
            RSD_SIZE_BYTE: data = {{(XLEN-8){~uns & byte_sel[7]}}, byte_sel};
            RSD_SIZE_HALF: data = {{(XLEN-16){~uns & half_sel[15]}}, half_sel};
            default:       data = raw;
        endcase
    end

endmodule

// File: rtl/k423_wb_stage.sv
// k423 writeback stage: holds one retiring instruction, waits for load data,
// drives the register-file write / forward ports and counts retirements.
module k423_wb_stage
    import k423_pkg::*;
#(
    parameter int unsigned XLEN  = CORE_XLEN,
    parameter int unsigned IDX_W = INST_RSDIDX_W
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  mem_vld_i,
    output logic                  mem_rdy_o,
    input  logic                  mem_rd_vld_i,
    input  logic [IDX_W-1:0]      mem_rd_idx_i,
    input  logic [XLEN-1:0]       mem_rd_data_i,
    input  logic                  mem_load_i,
    input  logic [RSD_SIZE_W-1:0] mem_load_size_i,
    input  logic                  mem_load_uns_i,
    input  logic [1:0]            mem_addr_lo_i,
    input  logic                  dmem_rsp_vld_i,
    input  logic [XLEN-1:0]       dmem_rsp_data_i,
    output logic                  wb_rd_vld_o,
    output logic [IDX_W-1:0]      wb_rd_idx_o,
    output logic [XLEN-1:0]       wb_rd_data_o,
    output logic                  wb_fwd_rd_vld_o,
    output logic [IDX_W-1:0]      wb_fwd_rd_idx_o,
    output logic [XLEN-1:0]       wb_fwd_rd_data_o,
    output logic                  wb_ld_pend_o,
    output logic [IDX_W-1:0]      wb_ld_pend_idx_o,
    output logic [63:0]           wb_instret_o
);

    wb_state_e   state_q;
    wb_entry_t   entry_q;
    logic [63:0] instret_q;
    logic [XLEN-1:0] ld_data;
    logic        accept;
    logic        rd_writes;

    // Response is aligned using the size/offset captured with the load.
    k423_wb_load_align #(
        .XLEN (XLEN)
    ) u_align (
        .raw     (dmem_rsp_data_i),
        .size    (entry_q.size),
        .uns     (entry_q.uns),
        .addr_lo (entry_q.addr_lo),
        .data    (ld_data)
    );

    // Ready is a pure state decode so MEM never sees a combinational loop.
    always_comb begin
        mem_rdy_o = (state_q != StWait);
        accept    = mem_vld_i & mem_rdy_o;
        rd_writes = entry_q.rd_vld & (entry_q.rd_idx != '0);
    end

    // FSM, entry register and retirement counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StEmpty;
            entry_q   <= '0;
            instret_q <= '0;
        end else begin
            if (state_q == StDone) begin
                instret_q <= instret_q + 64'd1;
            end
            unique case (state_q)
                StEmpty, StDone: begin
                    if (accept) begin
                        entry_q.rd_vld  <= mem_rd_vld_i;
                        entry_q.rd_idx  <= mem_rd_idx_i;
                        entry_q.data    <= mem_rd_data_i;
                        entry_q.load    <= mem_load_i;
                        entry_q.size    <= mem_load_size_i;
                        entry_q.uns     <= mem_load_uns_i;
                        entry_q.addr_lo <= mem_addr_lo_i;
                        state_q         <= mem_load_i ? StWait : StDone;
                    end else begin
                        state_q <= StEmpty;
                    end
                end
                StWait: begin
                    if (dmem_rsp_vld_i) begin
                        entry_q.data <= ld_data;
                        state_q      <= StDone;
                    end
                end
                default: state_q <= StEmpty;
            endcase
        end
    end

    // Output decodes from registered state only.
    always_comb begin
        wb_rd_vld_o      = (state_q == StDone) & rd_writes;
        wb_rd_idx_o      = entry_q.rd_idx;
        wb_rd_data_o     = entry_q.data;
        wb_fwd_rd_vld_o  = wb_rd_vld_o;
        wb_fwd_rd_idx_o  = wb_rd_idx_o;
        wb_fwd_rd_data_o = wb_rd_data_o;
        wb_ld_pend_o     = (state_q == StWait) & rd_writes;
        wb_ld_pend_idx_o = entry_q.rd_idx;
        wb_instret_o     = instret_q;
    end

endmodule

// File: tb/tb_k423_wb_stage.sv
// Scoreboard bench for k423_wb_stage: driver pushes expected writes and
// retirements, a monitor pops and compares them each cycle.
module tb_k423_wb_stage;
    import k423_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_vld, mem_rdy, mem_rd_vld, mem_load, mem_uns;
    logic [4:0]  mem_idx;
    logic [31:0] mem_data;
    logic [1:0]  mem_size, mem_lo;
    logic        rsp_vld;
    logic [31:0] rsp_data;
    logic        wb_vld, fwd_vld, pend;
    logic [4:0]  wb_idx, fwd_idx, pend_idx;
    logic [31:0] wb_data, fwd_data;
    logic [63:0] instret;

    k423_wb_stage dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .mem_vld_i        (mem_vld),
        .mem_rdy_o        (mem_rdy),
        .mem_rd_vld_i     (mem_rd_vld),
        .mem_rd_idx_i     (mem_idx),
        .mem_rd_data_i    (mem_data),
        .mem_load_i       (mem_load),
        .mem_load_size_i  (mem_size),
        .mem_load_uns_i   (mem_uns),
        .mem_addr_lo_i    (mem_lo),
        .dmem_rsp_vld_i   (rsp_vld),
        .dmem_rsp_data_i  (rsp_data),
        .wb_rd_vld_o      (wb_vld),
        .wb_rd_idx_o      (wb_idx),
        .wb_rd_data_o     (wb_data),
        .wb_fwd_rd_vld_o  (fwd_vld),
        .wb_fwd_rd_idx_o  (fwd_idx),
        .wb_fwd_rd_data_o (fwd_data),
        .wb_ld_pend_o     (pend),
        .wb_ld_pend_idx_o (pend_idx),
        .wb_instret_o     (instret)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [4:0]  idx;
        logic [31:0] data;
    } wr_t;

    wr_t         wr_q[$];
    int          ret_q[$];
    longint      exp_instret = 0;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    bit          waiting = 0;
    bit          p_rdv = 0;
    logic [4:0]  p_idx = '0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Reference load extension from plain arithmetic.
    function automatic logic [31:0] ext(logic [31:0] raw, logic [1:0] sz, logic uns,
                                        logic [1:0] lo);
        longint unsigned v;
        if (sz == RSD_SIZE_BYTE) begin
            v = (longint'(raw) >> (8 * lo)) % 256;
            if (!uns && v >= 128) v = v + 64'hFFFF_FF00;
        end else if (sz == RSD_SIZE_HALF) begin
            v = (longint'(raw) >> (16 * (lo / 2))) % 65536;
            if (!uns && v >= 32768) v = v + 64'hFFFF_0000;
        end else begin
            v = longint'(raw);
        end
        return v[31:0];
    endfunction

    // Record a retirement happening in the next cycle.
    function automatic void push_done(bit rdv, logic [4:0] idx, logic [31:0] data);
        wr_t w;
        ret_q.push_back(cyc + 1);
        if (rdv && idx != 0) begin
            w.cyc = cyc + 1; w.idx = idx; w.data = data;
            wr_q.push_back(w);
        end
    endfunction

    // Handshake and pending-load checks, made at the negedge.
    task automatic cycle_checks();
        chk("mem_rdy", {63'd0, mem_rdy}, {63'd0, !waiting});
        chk("ld_pend", {63'd0, pend}, {63'd0, waiting && p_rdv && p_idx != 0});
        if (waiting && p_rdv && p_idx != 0) chk("ld_pend_idx", {59'd0, pend_idx}, {59'd0, p_idx});
    endtask

    task automatic junk_mem();
        mem_vld = 1'($urandom_range(0, 1));
        mem_rd_vld = 1'b1; mem_idx = 5'($urandom_range(1, 31)); mem_data = $urandom;
        mem_load = 1'($urandom_range(0, 1)); mem_size = 2'($urandom_range(0, 2));
        mem_uns = 1'($urandom_range(0, 1)); mem_lo = 2'($urandom_range(0, 3));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            cycle_checks();
            mem_vld = 1'b0;
            rsp_vld = ($urandom_range(0, 3) == 0);
            rsp_data = $urandom;
            @(negedge clk);
        end
        rsp_vld = 1'b0;
    endtask

    // Issue one instruction; for loads, answer after lat cycles with rsp.
    task automatic send(input bit rdv, input logic [4:0] idx, input logic [31:0] data,
                        input bit ld, input logic [1:0] sz, input bit uns,
                        input logic [1:0] lo, input int lat, input logic [31:0] rsp);
        cycle_checks();
        mem_vld = 1'b1; mem_rd_vld = rdv; mem_idx = idx; mem_data = data;
        mem_load = ld; mem_size = sz; mem_uns = uns; mem_lo = lo;
        rsp_vld = ($urandom_range(0, 3) == 0);
        rsp_data = $urandom;
        if (!ld) begin
            push_done(rdv, idx, data);
        end else begin
            waiting = 1; p_rdv = rdv; p_idx = idx;
        end
        @(negedge clk);
        rsp_vld = 1'b0;
        if (ld) begin
            for (int i = 1; i < lat; i++) begin
                cycle_checks();
                junk_mem();
                @(negedge clk);
            end
            cycle_checks();
            junk_mem();
            rsp_vld = 1'b1; rsp_data = rsp;
            push_done(rdv, idx, ext(rsp, sz, uns, lo));
            waiting = 0;
            @(negedge clk);
            rsp_vld = 1'b0;
        end
        mem_vld = 1'b0;
    endtask

    // Monitor: sample one time unit after each rising edge.
    always begin
        @(posedge clk);
        cyc = cyc + 1;
        #1;
        while (wr_q.size() > 0 && wr_q[0].cyc < cyc) begin
            chk("missing_write_cycle", 64'(cyc), 64'(wr_q[0].cyc));
            void'(wr_q.pop_front());
        end
        if (wb_vld === 1'b1) begin
            if (wr_q.size() == 0 || wr_q[0].cyc != cyc) begin
                chk("unexpected_write", {63'd0, wb_vld}, 64'd0);
            end else begin
                chk("wr_idx", {59'd0, wb_idx}, {59'd0, wr_q[0].idx});
                chk("wr_data", {32'd0, wb_data}, {32'd0, wr_q[0].data});
                void'(wr_q.pop_front());
            end
        end else begin
            chk("wr_vld_low", {63'd0, wb_vld}, 64'd0);
        end
        chk("fwd_vld", {63'd0, fwd_vld}, {63'd0, wb_vld});
        chk("fwd_idx", {59'd0, fwd_idx}, {59'd0, wb_idx});
        chk("fwd_data", {32'd0, fwd_data}, {32'd0, wb_data});
        while (ret_q.size() > 0 && ret_q[0] < cyc) begin
            exp_instret++;
            void'(ret_q.pop_front());
        end
        chk("instret", instret, 64'(exp_instret));
    end

    initial begin
        rst = 1'b1; mem_vld = 0; mem_rd_vld = 0; mem_idx = 0; mem_data = 0;
        mem_load = 0; mem_size = 0; mem_uns = 0; mem_lo = 0; rsp_vld = 0; rsp_data = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Directed cases.
        send(1, 5'd5, 32'hDEAD_BEEF, 0, RSD_SIZE_WORD, 0, 2'd0, 0, 0);
        idle(1);
        send(1, 5'd0, 32'h1234_5678, 0, RSD_SIZE_WORD, 0, 2'd0, 0, 0);
        idle(1);
        send(1, 5'd7, 32'h0, 1, RSD_SIZE_BYTE, 0, 2'd3, 4, 32'h80FF_0000);
        send(1, 5'd7, 32'h0, 1, RSD_SIZE_BYTE, 1, 2'd3, 4, 32'h80FF_0000);
        send(1, 5'd9, 32'h0, 1, RSD_SIZE_HALF, 0, 2'd2, 2, 32'h8001_1234);
        send(1, 5'd9, 32'h0, 1, RSD_SIZE_HALF, 1, 2'd0, 2, 32'h8001_1234);
        send(1, 5'd3, 32'h0, 1, RSD_SIZE_WORD, 0, 2'd0, 1, 32'hCAFE_F00D);
        idle(2);
        // Stream: three non-loads, a load answered next cycle, one non-load.
        send(1, 5'd1, 32'h1111_1111, 0, RSD_SIZE_WORD, 0, 2'd0, 0, 0);
        send(1, 5'd2, 32'h2222_2222, 0, RSD_SIZE_WORD, 0, 2'd0, 0, 0);
        send(1, 5'd3, 32'h3333_3333, 0, RSD_SIZE_WORD, 0, 2'd0, 0, 0);
        send(1, 5'd4, 32'h0, 1, RSD_SIZE_BYTE, 1, 2'd1, 1, 32'h0000_AB00);
        send(1, 5'd6, 32'h6666_6666, 0, RSD_SIZE_WORD, 0, 2'd0, 0, 0);
        idle(3);

        // Reset while a load waits, then a stray response.
        cycle_checks();
        mem_vld = 1; mem_rd_vld = 1; mem_idx = 5'd12; mem_data = 0; mem_load = 1;
        mem_size = RSD_SIZE_WORD; mem_uns = 0; mem_lo = 0;
        waiting = 1; p_rdv = 1; p_idx = 5'd12;
        @(negedge clk);
        mem_vld = 0;
        repeat (2) begin
            cycle_checks();
            @(negedge clk);
        end
        rst = 1'b1;
        waiting = 0; wr_q.delete(); ret_q.delete(); exp_instret = 0;
        @(negedge clk);
        rst = 1'b0;
        cycle_checks();
        rsp_vld = 1'b1; rsp_data = 32'h5A5A_5A5A;
        @(negedge clk);
        rsp_vld = 1'b0;
        idle(3);

        // Randomized traffic.
        for (int n = 0; n < 300; n++) begin
            send(($urandom_range(0, 9) != 0), 5'($urandom_range(0, 31)), $urandom,
                 ($urandom_range(0, 4) < 2), 2'($urandom_range(0, 2)),
                 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 int'($urandom_range(1, 4)), $urandom);
            if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 2)));
        end
        idle(4);
        chk("scoreboard_drained", 64'(wr_q.size() + ret_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
